vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
Framebuffer fetch stage directly upstream of the vga output block. It reads RGB565 pixels from the shared framebuffer memory through a req/ack handshake. Pixels are buffered in a small prefetch FIFO, so variable memory latency from CPU arbitration is absorbed. Each pixel is expanded to 8-bit red/green/blue and presented to the display stage on demand.

Parameters:
H_RES, 640, visible pixels per line
V_RES, 480, visible lines per frame
ADDR_BITS, 19, framebuffer word-address width; must hold H_RES*V_RES
FB_BASE, 0, word address of pixel (0,0)
FIFO_DEPTH, 16, prefetch entries; power of two, at least 4

Ports:
clk_50MHz  input  1  system clock
clear  input  1  asynchronous reset, active-high
frame_start  input  1  one-cycle pulse during vertical blank; restarts the frame
pixel_req  input  1  one-cycle pulse per visible pixel consumed; at most every 2nd cycle
mem_req  output  1  read request to framebuffer arbiter
mem_addr  output  ADDR_BITS  read word address
mem_ack  input  1  read data valid; transfer occurs when mem_req && mem_ack
mem_data  input  16  RGB565 pixel word {R[15:11],G[10:5],B[4:0]}
red_out  output  8  expanded red
green_out  output  8  expanded green
blue_out  output  8  expanded blue
underflow  output  1  sticky: pixel_req arrived with FIFO empty; cleared by frame_start
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (clear high, async): state IDLE; mem_req=0; mem_addr=FB_BASE; RGB outputs=0; underflow=0; FIFO empty (fifo_level=0); fetch count=0.
- FSM states:
  - IDLE: entered at reset; never requests memory. Leaves only on frame_start.
  - FILL: fetches pixels.
  - DONE: entered when the fetch count reaches H_RES*V_RES; mem_req=0 until the next frame_start.
- frame_start (any state), applied on the next edge:
  - FIFO flushed; mem_addr=FB_BASE; fetch count=0; underflow=0; RGB=0; state FILL.
- FILL request rule:
  - mem_req is asserted when fifo_level < FIFO_DEPTH and the fetch count < H_RES*V_RES.
  - Only one request is outstanding at a time.
  - mem_req and mem_addr stay stable until mem_ack.
- On handshake (mem_req && mem_ack):
  - mem_data is written to the FIFO the same edge.
  - mem_addr increments and the fetch count increments.
  - mem_req may stay high for the next address with no idle cycle (back-to-back).
- Abort: frame_start overrides a pending request. mem_req drops on the next edge. The arbiter must tolerate the withdrawn read, since reads have no side effects. An ack coinciding with frame_start is discarded.
- Pop and output:
  - pixel_req with FIFO non-empty pops the head. The RGB outputs are registered and valid 1 cycle after pixel_req, then held until the next pop.
  - pixel_req with FIFO empty: RGB=0 (black) the next cycle, underflow set, no pop.
- Colour expansion:
  - red_out = {R, R[4:2]}
  - green_out = {G, G[5:4]}
  - blue_out = {B, B[4:2]}
  - Examples: 0xFFFF gives FF/FF/FF; 0x0000 gives 00/00/00.
- Simultaneous push and pop: both occur and fifo_level is unchanged. A push into a full FIFO cannot occur because no request is issued when full.
- Simultaneous frame_start and pixel_req: flush wins; no pop; RGB=0.
- FIFO pointers wrap modulo FIFO_DEPTH. fifo_level distinguishes full (FIFO_DEPTH) from empty (0).
- The address never wraps within a frame. The last address is FB_BASE + H_RES*V_RES - 1.

Test Plan:
- Reset then idle, with mem_ack tied high for 100 cycles -> mem_req stays 0, fifo_level=0, RGB=0, mem_addr=FB_BASE.
- Zero-latency memory: frame_start, then mem_ack tied high, no pixel_req -> 16 requests at addresses 0..15; fifo_level=16; mem_req drops; mem_addr=16.
- Pop and expand: FIFO holding 0xF800, 0x07E0, 0x001F, 0x8410; pixel_req every 2nd cycle -> one cycle later RGB = FF/00/00, 00/FF/00, 00/00/FF, 84/82/84; fifo_level decrements by 1 each pop.
- Slow memory (ack 5 cycles after req) with pixel_req every 2 cycles -> FIFO drains. The pixel_req that arrives when the FIFO is empty gives RGB=000000 the next cycle, underflow=1. underflow stays 1 until frame_start, then returns to 0.
- Abort: frame_start while a request at address 37 is pending, with ack arriving in the same cycle -> data discarded; fifo_level=0; the next request is at FB_BASE.
- Full frame, small parameters (H_RES=4, V_RES=2, zero-latency memory, pixel_req every 2nd cycle) -> exactly 8 handshakes at addresses 0..7; state DONE; mem_req=0 until the next frame_start; all 8 pixels output in order.

Source files
------------

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch stage: pulls RGB565 words over a req/ack port into a prefetch
// FIFO and pops them on demand as registered 8-bit-per-channel colour.
module vga_pixel_fetch #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned ADDR_BITS  = 19,
  parameter int unsigned FB_BASE    = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_50MHz,
  input  logic                          clear,
  input  logic                          frame_start,
  input  logic                          pixel_req,
  output logic                          mem_req,
  output logic [ADDR_BITS-1:0]          mem_addr,
  input  logic                          mem_ack,
  input  logic [15:0]                   mem_data,
  output logic [7:0]                    red_out,
  output logic [7:0]                    green_out,
  output logic [7:0]                    blue_out,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned TOTAL = H_RES * V_RES;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t               state_q, state_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [23:0]          rgb_q, rgb_d;
  logic                 uf_q, uf_d;
  logic                 push, pop;
  logic [15:0]          head;
  logic [15:0]          fifo_mem [FIFO_DEPTH];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    rgb_d     = rgb_q;
    uf_d      = uf_q;
    head      = fifo_mem[rd_ptr_q];
    // frame_start masks both the handshake and the pop: the flush must win
    push      = mem_req_q && mem_ack && !frame_start;
    pop       = pixel_req && (level_q != '0) && !frame_start;

    if (frame_start) begin
      state_d  = FILL;
      addr_d   = ADDR_BITS'(FB_BASE);
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      rgb_d    = '0;
      uf_d     = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        addr_d   = addr_q + ADDR_BITS'(1);
        cnt_d    = cnt_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        rgb_d    = {head[15:11], head[15:13], head[10:5], head[10:9],
                    head[4:0], head[4:2]};
      end else if (pixel_req) begin
        rgb_d = '0;
        uf_d  = 1'b1;
      end
      if (push && !pop) begin
        level_d = level_q + LVL_W'(1);
      end else if (pop && !push) begin
        level_d = level_q - LVL_W'(1);
      end
      if (state_q == FILL && cnt_d == CNT_W'(TOTAL)) begin
        state_d = DONE;
      end
    end

    // Request is registered from next-state values, so it stays stable until ack
    mem_req_d = (state_d == FILL) && (level_d < LVL_W'(FIFO_DEPTH)) &&
                (cnt_d < CNT_W'(TOTAL));
  end

  always_ff @(posedge clk_50MHz or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      addr_q    <= ADDR_BITS'(FB_BASE);
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rgb_q     <= '0;
      uf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rgb_q     <= rgb_d;
      uf_q      <= uf_d;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_data;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = addr_q;
  assign red_out    = rgb_q[23:16];
  assign green_out  = rgb_q[15:8];
  assign blue_out   = rgb_q[7:0];
  assign underflow  = uf_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: a default-size instance checked every cycle against a
// queue-based model, plus a 4x2 instance for the whole-frame sequence.
module tb_vga_pixel_fetch;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TOTAL_B = 640 * 480;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        clear, frame_start, pixel_req, mem_req, mem_ack, uf;
  logic [18:0] mem_addr;
  logic [15:0] mem_data;
  logic [7:0]  r, g, b;
  logic [4:0]  lvl;

  logic        frame_start_s, pixel_req_s, mem_req_s, mem_ack_s, uf_s;
  logic [18:0] mem_addr_s;
  logic [15:0] mem_data_s;
  logic [7:0]  r_s, g_s, b_s;
  logic [4:0]  lvl_s;

  logic [15:0] fb [256];
  assign mem_data   = fb[mem_addr[7:0]];
  assign mem_data_s = fb[mem_addr_s[7:0]];

  vga_pixel_fetch dut (
    .clk_50MHz(clk), .clear(clear), .frame_start(frame_start), .pixel_req(pixel_req),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .red_out(r), .green_out(g), .blue_out(b), .underflow(uf), .fifo_level(lvl)
  );

  vga_pixel_fetch #(.H_RES(4), .V_RES(2)) dut_s (
    .clk_50MHz(clk), .clear(clear), .frame_start(frame_start_s), .pixel_req(pixel_req_s),
    .mem_req(mem_req_s), .mem_addr(mem_addr_s), .mem_ack(mem_ack_s), .mem_data(mem_data_s),
    .red_out(r_s), .green_out(g_s), .blue_out(b_s), .underflow(uf_s), .fifo_level(lvl_s)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] w);
    int unsigned r5, g6, b5;
    logic [7:0] r8, g8, b8;
    r5 = (int'(w) >> 11) & 31;
    g6 = (int'(w) >> 5) & 63;
    b5 = int'(w) & 31;
    r8 = 8'(r5 * 8 + r5 / 4);
    g8 = 8'(g6 * 4 + g6 / 16);
    b8 = 8'(b5 * 8 + b5 / 4);
    return {r8, g8, b8};
  endfunction

  // Reference model: contents of the FIFO, pixels fetched this frame, sticky flag
  logic [15:0] mq[$];
  int unsigned mcount;
  bit          mactive, muf, model_on;
  logic [23:0] mrgb;

  int          ack_mode;
  int          lat_cnt;
  logic [18:0] hs_b[$];
  logic [18:0] hs_s[$];
  logic [23:0] out_s[$];

  task automatic tick();
    bit hs, fs, pr, pr_s;
    case (ack_mode)
      1: begin
        if (mem_req) begin
          mem_ack = (lat_cnt >= 4);
          lat_cnt = mem_ack ? 0 : lat_cnt + 1;
        end else begin
          mem_ack = 1'b0;
          lat_cnt = 0;
        end
      end
      2: mem_ack = ($urandom_range(0, 2) == 0);
      default: ;
    endcase
    hs = mem_req && mem_ack;
    fs = frame_start;
    pr = pixel_req;
    pr_s = pixel_req_s;
    if (model_on && mem_req) chk("mem_addr", 32'(mem_addr), mcount);
    if (hs && !fs) hs_b.push_back(mem_addr);
    if (mem_req_s && mem_ack_s && !frame_start_s) hs_s.push_back(mem_addr_s);
    @(posedge clk);
    #1;
    if (pr_s) out_s.push_back({r_s, g_s, b_s});
    if (fs) begin
      mq.delete();
      mcount  = 0;
      muf     = 1'b0;
      mrgb    = '0;
      mactive = 1'b1;
    end else begin
      if (pr) begin
        if (mq.size() > 0) mrgb = expand(mq.pop_front());
        else begin
          mrgb = '0;
          muf  = 1'b1;
        end
      end
      if (hs) begin
        mq.push_back(fb[mcount % 256]);
        mcount++;
      end
    end
    if (model_on) begin
      chk("fifo_level", 32'(lvl), mq.size());
      chk("rgb", 32'({r, g, b}), 32'(mrgb));
      chk("underflow", 32'(uf), 32'(muf));
      chk("mem_req", 32'(mem_req),
          32'(mactive && mq.size() < DEPTH && mcount < TOTAL_B));
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [7:0]  er, eg, eb;
  } vec_t;
  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    tbl[0] = '{16'hF800, 8'hFF, 8'h00, 8'h00};
    tbl[1] = '{16'h07E0, 8'h00, 8'hFF, 8'h00};
    tbl[2] = '{16'h001F, 8'h00, 8'h00, 8'hFF};
    tbl[3] = '{16'h8410, 8'h84, 8'h82, 8'h84};
    tbl[4] = '{16'hFFFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[5] = '{16'h0000, 8'h00, 8'h00, 8'h00};
    tbl[6] = '{16'h1234, 8'h10, 8'h45, 8'hA5};
    tbl[7] = '{16'h0821, 8'h08, 8'h04, 8'h08};
    for (int i = 0; i < 256; i++) fb[i] = 16'($urandom);

    model_on = 1'b0;
    ack_mode = 0;
    lat_cnt  = 0;
    clear = 1'b1;
    frame_start = 1'b0; pixel_req = 1'b0; mem_ack = 1'b0;
    frame_start_s = 1'b0; pixel_req_s = 1'b0; mem_ack_s = 1'b0;
    #5;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_level", 32'(lvl), 0);
    chk("rst_rgb", 32'({r, g, b}), 0);
    chk("rst_underflow", 32'(uf), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    mq.delete(); mcount = 0; mactive = 1'b0; muf = 1'b0; mrgb = '0;
    model_on = 1'b1;

    // Idle with ack stuck high: nothing may be requested
    mem_ack = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk("idle_addr", 32'(mem_addr), 0);

    // Zero-latency fill
    hs_b.delete();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("fill_count", hs_b.size(), 16);
    for (int i = 0; i < hs_b.size(); i++) chk("fill_addr", 32'(hs_b[i]), i);
    chk("fill_level", 32'(lvl), 16);
    chk("fill_mem_req", 32'(mem_req), 0);
    chk("fill_next_addr", 32'(mem_addr), 16);

    // Table-driven colour expansion
    for (int i = 0; i < 8; i++) fb[i] = tbl[i].word;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    mem_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pixel_req = 1'b1; tick(); pixel_req = 1'b0;
      chk("tbl_rgb", 32'({r, g, b}), 32'({tbl[i].er, tbl[i].eg, tbl[i].eb}));
      chk("tbl_level", 32'(lvl), 15 - i);
      tick();
      chk("tbl_hold", 32'({r, g, b}), 32'({tbl[i].er, tbl[i].eg, tbl[i].eb}));
    end

    // Slow memory drains the FIFO into underflow
    ack_mode = 1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      pixel_req = (i % 2 == 0);
      found = pixel_req && (lvl == 0);
      tick();
      pixel_req = 1'b0;
      if (found) begin
        chk("uf_rgb", 32'({r, g, b}), 0);
        chk("uf_flag", 32'(uf), 1);
      end
    end
    chk("uf_reached", 32'(found), 1);
    for (int i = 0; i < 10; i++) tick();
    chk("uf_sticky", 32'(uf), 1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("uf_cleared", 32'(uf), 0);

    // Abort a pending read at address 37 with a coincident ack
    ack_mode = 0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      found = mem_req && (mem_addr == 37);
      if (!found) begin
        mem_ack = 1'b1;
        pixel_req = (i % 2 == 0);
        tick();
        pixel_req = 1'b0;
      end
    end
    chk("abort_reached", 32'(found), 1);
    mem_ack = 1'b0; tick();
    frame_start = 1'b1; mem_ack = 1'b1; tick();
    frame_start = 1'b0; mem_ack = 1'b0;
    chk("abort_level", 32'(lvl), 0);
    chk("abort_mem_req", 32'(mem_req), 1);
    chk("abort_addr", 32'(mem_addr), 0);
    tick();
    chk("abort_level2", 32'(lvl), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++) fb[i] = 16'($urandom);
    ack_mode = 2;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    for (int i = 0; i < 800; i++) begin
      frame_start = ($urandom_range(0, 149) == 0);
      pixel_req   = !pixel_req && ($urandom_range(0, 1) == 1);
      tick();
    end
    frame_start = 1'b0; pixel_req = 1'b0;
    ack_mode = 0; mem_ack = 1'b0;

    // Whole 4x2 frame on the small instance
    hs_s.delete(); out_s.delete();
    mem_ack_s = 1'b1;
    frame_start_s = 1'b1; tick(); frame_start_s = 1'b0;
    for (int c = 0; c < 40; c++) begin
      pixel_req_s = (c >= 2 && c <= 16 && c % 2 == 0);
      tick();
    end
    pixel_req_s = 1'b0;
    chk("frame_hs_count", hs_s.size(), 8);
    for (int i = 0; i < hs_s.size(); i++) chk("frame_hs_addr", 32'(hs_s[i]), i);
    chk("frame_out_count", out_s.size(), 8);
    for (int i = 0; i < out_s.size(); i++) chk("frame_pixel", 32'(out_s[i]), 32'(expand(fb[i])));
    chk("frame_level", 32'(lvl_s), 0);
    chk("frame_underflow", 32'(uf_s), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("done_mem_req", 32'(mem_req_s), 0);
    end
    frame_start_s = 1'b1; tick(); frame_start_s = 1'b0;
    chk("restart_mem_req", 32'(mem_req_s), 1);
    chk("restart_addr", 32'(mem_addr_s), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
